dircc_avalon_st_source: RTL and testbench
=========================================

Name: dircc_avalon_st_source

Overview:
Avalon-ST packet source that sits on the transmit side of the DiRCC Avalon-ST link and drives the sink port of dircc_avalon_st_terminal. On command it emits a burst of fixed-length packets with sop/eop/empty framing and honours sink backpressure. Packet data follows a deterministic pattern, so the terminal and any downstream checker can verify the content.

Parameters:
- DATA_WIDTH, 32: data bus width; must be >= 32.
- EMPTY_WIDTH, 2: width of src_empty.
- PACKET_WORDS, 3: beats per packet; must be >= 1.
- LAST_EMPTY, 0: src_empty value on the eop beat.
- GAP_CYCLES, 0: idle cycles inserted between packets within a burst.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle burst request
- num_packets  in  16  number of packets in the burst; sampled on an accepted start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when the burst completes
- packets_sent  out  16  count of packets completed (eop accepted) in the current or last burst
- src_data  out  DATA_WIDTH  Avalon-ST data
- src_valid  out  1  Avalon-ST valid
- src_ready  in  1  Avalon-ST ready, readyLatency 0
- src_startofpacket  out  1  sop
- src_endofpacket  out  1  eop
- src_empty  out  EMPTY_WIDTH  empty

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
- Reset mid-packet:
  - Outputs return to 0 on the next cycle.
  - The packet is abandoned with no eop.
  - The latched count, word index and sequence number are cleared.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - start is accepted only in IDLE; start in SEND or GAP is ignored.
  - On an accepted start: latch num_packets into remaining, clear packets_sent and the packet sequence number, then:
    - If num_packets == 0: pulse done on the next cycle and stay in IDLE; no traffic.
    - Otherwise: go to SEND. src_valid=1 and sop=1 on the cycle after start; busy=1 from that same cycle.
- SEND:
  - A beat transfers when src_valid && src_ready.
  - While src_valid && !src_ready, src_data, sop, eop and empty hold stable.
  - Data for beat k (0-based) of packet p (0-based within the burst) = {zero-extend, p[15:0], k[15:0]}.
  - sop=1 only when k==0.
  - eop=1 only when k==PACKET_WORDS-1; src_empty=LAST_EMPTY on that beat and 0 on all other beats.
  - PACKET_WORDS==1: sop and eop are both set on the single beat.
  - On eop transfer: packets_sent++ and remaining--.
    - If remaining reaches 0: go to IDLE, src_valid=0 on the next cycle, done=1 for exactly that cycle, busy=0 on that cycle.
    - Else if GAP_CYCLES>0: go to GAP with src_valid=0.
    - Else: stay in SEND; the next packet's sop beat follows back-to-back with src_valid held high.
- GAP:
  - Count GAP_CYCLES cycles, then go to SEND with the next packet's sop beat.
  - busy stays 1.
- Counter widths:
  - Word index is ceil(log2(PACKET_WORDS)) bits, minimum 1; it wraps to 0 after eop.
  - Sequence number and packets_sent are 16 bits.
  - num_packets=16'hFFFF completes without overflow.
- Burst throughput: with src_ready held at 1 and GAP_CYCLES=0, the burst produces num_packets*PACKET_WORDS consecutive valid beats.

Optional Feature:
- Macro: DIRCC_AVALON_ST_SOURCE_ERROR_EN.
- Defined:
  - Adds input error_packet[15:0], latched on an accepted start.
  - Adds output src_error[0:0], reset 0.
  - src_error=1 only on the eop beat of the packet whose sequence number equals the latched error_packet; it is held stable under backpressure and is 0 on all other beats.
  - This drives the terminal's error path.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset for 10 cycles, start with num_packets=1, src_ready=1 -> 3 consecutive beats with data 0x00000000, 0x00000001, 0x00000002; sop on beat 0, eop on beat 2, empty=0; done pulses once; packets_sent=1.
- num_packets=2, GAP_CYCLES=0, src_ready=1 -> 6 back-to-back valid beats; second packet data 0x00010000..0x00010002; done on the cycle after the last beat.
- Same burst with src_ready toggling 1,0,0,1,... -> no beat lost or duplicated; data and framing are stable while stalled; packets_sent=2.
- start with num_packets=0 -> src_valid never asserts; done pulses 1 cycle later; busy stays 0. start asserted while busy -> ignored, count unchanged.
- Reset asserted after beat 1 of a packet -> all outputs 0 on the next cycle; a new start then begins at data 0x00000000 with sop.
- ERROR_EN, num_packets=3, error_packet=1 -> src_error=1 only on the eop beat with data 0x00010002.

Source files
------------

// File: rtl/dircc_avalon_st_source.sv
// Avalon-ST burst packet source: emits num_packets fixed-length packets with a
// {seq, word} data pattern. Define DIRCC_AVALON_ST_SOURCE_ERROR_EN to add src_error.
module dircc_avalon_st_source #(
  parameter int DATA_WIDTH   = 32,
  parameter int EMPTY_WIDTH  = 2,
  parameter int PACKET_WORDS = 3,
  parameter int LAST_EMPTY   = 0,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            num_packets,
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
  input  logic [15:0]            error_packet,
  output logic [0:0]             src_error,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            packets_sent,
  output logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic                   src_startofpacket,
  output logic                   src_endofpacket,
  output logic [EMPTY_WIDTH-1:0] src_empty
);

  localparam int WW = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [WW-1:0] LAST_W   = WW'(PACKET_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   sent_q, sent_d;
  logic [WW-1:0] word_q, word_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic [15:0]   err_pkt_q, err_pkt_d;

  logic valid, eop_beat, xfer;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    seq_d       = seq_q;
    sent_d      = sent_q;
    word_d      = word_q;
    gap_d       = gap_q;
    err_pkt_d   = err_pkt_q;
    done_d      = 1'b0;
    valid       = (state_q == SEND);
    eop_beat    = (word_q == LAST_W);
    xfer        = valid && src_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = num_packets;
          sent_d      = '0;
          seq_d       = '0;
          word_d      = '0;
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
          err_pkt_d   = error_packet;
`endif
          if (num_packets == 16'd0) done_d = 1'b1;
          else                      state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (eop_beat) begin
            word_d      = '0;
            sent_d      = sent_q + 16'd1;
            seq_d       = seq_q + 16'd1;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = SEND;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      seq_q       <= '0;
      sent_q      <= '0;
      word_q      <= '0;
      gap_q       <= '0;
      done_q      <= 1'b0;
      err_pkt_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      seq_q       <= seq_d;
      sent_q      <= sent_d;
      word_q      <= word_d;
      gap_q       <= gap_d;
      done_q      <= done_d;
      err_pkt_q   <= err_pkt_d;
    end
  end

  // Beat outputs come straight from registers, so they hold while stalled.
  always_comb begin
    src_data          = '0;
    src_valid         = valid;
    src_startofpacket = valid && (word_q == '0);
    src_endofpacket   = valid && eop_beat;
    src_empty         = (valid && eop_beat) ? EMPTY_WIDTH'(LAST_EMPTY) : '0;
    if (valid) src_data[31:0] = {seq_q, 16'(word_q)};
    busy              = (state_q != IDLE);
    done              = done_q;
    packets_sent      = sent_q;
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
    src_error         = valid && eop_beat && (seq_q == err_pkt_q);
`endif
  end

  logic unused_ok;
  assign unused_ok = ^err_pkt_q;

endmodule

// File: tb/tb_dircc_avalon_st_source.sv
// Bench for dircc_avalon_st_source: directed vector table, hand-written corner
// sequences, then random bursts with random backpressure against a beat queue model.
module tb_dircc_avalon_st_source;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset, start, src_ready;
  logic [15:0]   num_packets;
  logic          busy, done, src_valid, src_sop, src_eop;
  logic [15:0]   packets_sent;
  logic [DW-1:0] src_data;
  logic [EW-1:0] src_empty;
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
  logic [15:0]   error_packet;
  logic [0:0]    src_error;
`endif

  dircc_avalon_st_source #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .PACKET_WORDS(PW),
                           .LAST_EMPTY(0), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .start(start), .num_packets(num_packets),
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
    .error_packet(error_packet), .src_error(src_error),
`endif
    .busy(busy), .done(done), .packets_sent(packets_sent),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_startofpacket(src_sop), .src_endofpacket(src_eop), .src_empty(src_empty));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [15:0] num;
    logic        ready;
    logic        valid, sop, eop;
    logic [31:0] data;
    logic        busy, done;
    logic [15:0] ps;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        sop, eop, err;
  } beat_t;

  vec_t  tbl[16];
  beat_t q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // start num ready | valid sop eop data busy done ps
    tbl[0]  = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1,     1'b1, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2,     1'b1, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 16'd0};
    tbl[6]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 16'd0};
    tbl[9]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1,     1'b1, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2,     1'b1, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10000, 1'b1, 1'b0, 16'd1};
    tbl[12] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10001, 1'b1, 1'b0, 16'd1};
    tbl[13] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10002, 1'b1, 1'b0, 16'd1};
    tbl[14] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 16'd2};
    tbl[15] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd2};

    reset = 1'b1; start = 1'b0; src_ready = 1'b0; num_packets = '0;
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
    error_packet = '0;
`endif
    repeat (10) tick();
    chk("reset valid", src_valid, 0);
    chk("reset data", src_data, 0);
    chk("reset sop/eop", {src_sop, src_eop}, 0);
    chk("reset busy/done", {busy, done}, 0);
    chk("reset packets_sent", packets_sent, 0);
    chk("reset empty", src_empty, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; num_packets = tbl[i].num; src_ready = tbl[i].ready;
      tick();
      chk($sformatf("vec%0d valid", i), src_valid, tbl[i].valid);
      chk($sformatf("vec%0d sop", i), src_sop, tbl[i].sop);
      chk($sformatf("vec%0d eop", i), src_eop, tbl[i].eop);
      chk($sformatf("vec%0d data", i), src_data, tbl[i].data);
      chk($sformatf("vec%0d empty", i), src_empty, 0);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d done", i), done, tbl[i].done);
      chk($sformatf("vec%0d packets_sent", i), packets_sent, tbl[i].ps);
    end
    start = 1'b0;

    // Reset after beat 1 abandons the packet; the next burst restarts cleanly.
    start = 1'b1; num_packets = 16'd1; src_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("midrst pre data", src_data, 32'h1);
    reset = 1'b1;
    tick();
    chk("midrst valid", src_valid, 0);
    chk("midrst data", src_data, 0);
    chk("midrst sop/eop", {src_sop, src_eop}, 0);
    chk("midrst busy/done", {busy, done}, 0);
    chk("midrst packets_sent", packets_sent, 0);
    reset = 1'b0;
    start = 1'b1; num_packets = 16'd1;
    tick();
    start = 1'b0;
    chk("restart data", src_data, 32'h0);
    chk("restart sop/valid", {src_sop, src_valid}, 2'b11);
    repeat (3) tick();
    chk("restart done", done, 1);
    chk("restart packets_sent", packets_sent, 1);

`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
    start = 1'b1; num_packets = 16'd3; error_packet = 16'd1; src_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("errpkt beat%0d error", i), src_error, (src_data == 32'h10002));
      tick();
    end
    chk("errpkt done", done, 1);
`endif

    // Random bursts with random backpressure and ignored mid-burst starts.
    for (int b = 0; b < 10; b++) begin
      int n, err, cyc;
      logic stalled, seen_done;
      beat_t prev;
      n   = $urandom_range(1, 5);
      err = $urandom_range(0, n);
      q.delete();
      for (int p = 0; p < n; p++)
        for (int k = 0; k < PW; k++)
          q.push_back('{data: (p << 16) | k, sop: (k == 0), eop: (k == PW - 1),
                        err: (k == PW - 1) && (p == err)});
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
      error_packet = 16'(err);
`endif
      start = 1'b1; num_packets = 16'(n);
      tick();
      start = 1'b0;
      stalled = 1'b0; seen_done = 1'b0; prev = '{default: '0};
      for (cyc = 0; cyc < 500; cyc++) begin
        if (done) begin seen_done = 1'b1; break; end
        if (stalled) begin
          chk($sformatf("rnd%0d stall hold", b), {src_valid, src_data, src_sop, src_eop},
              {1'b1, prev.data, prev.sop, prev.eop});
        end
        src_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        num_packets = 16'($urandom_range(1, 9));
        if (src_valid && src_ready) begin
          if (q.size() == 0) chk($sformatf("rnd%0d extra beat", b), 1, 0);
          else begin
            beat_t e;
            e = q.pop_front();
            chk($sformatf("rnd%0d beat", b), {src_data, src_sop, src_eop, 2'(src_empty)},
                {e.data, e.sop, e.eop, 2'b00});
`ifdef DIRCC_AVALON_ST_SOURCE_ERROR_EN
            chk($sformatf("rnd%0d error", b), src_error, e.err);
`endif
          end
        end
        stalled = src_valid && !src_ready;
        prev = '{data: src_data, sop: src_sop, eop: src_eop, err: 1'b0};
        tick();
      end
      start = 1'b0;
      chk($sformatf("rnd%0d done seen", b), seen_done, 1);
      chk($sformatf("rnd%0d beats left", b), q.size(), 0);
      chk($sformatf("rnd%0d packets_sent", b), packets_sent, n);
      chk($sformatf("rnd%0d busy after", b), busy, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
